avl_gpio_port: RTL
==================

AVL_GPIO_PORT -- requirements
Module: avl_gpio_port

Interface
REQ-001 Parameter WIDTH, default 8, number of GPIO bits (1..32).
REQ-002 Parameter RESET_VALUE, default 0, reset value of the output data register (WIDTH bits).
REQ-003 Parameter EDGE_TYPE, default 0, edge that sets a capture bit: 0 = rising, 1 = falling, 2 = any.
REQ-004 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 address  input  3  Avalon-MM register select.
REQ-007 chipselect  input  1  slave select.
REQ-008 write_n / read_n  input  1 each  active-low write and read strobes.
REQ-009 writedata  input  32  write data; bits above WIDTH-1 SHALL be ignored.
REQ-010 readdata  output  32  registered read data; bits above WIDTH-1 SHALL read 0.
REQ-011 pin_in  input  WIDTH  asynchronous pin inputs.
REQ-012 pin_out / pin_oe  output  WIDTH each  pin drive value and per-bit output enable.
REQ-013 irq  output  1  level interrupt, active-high.

Function
REQ-014 Register map: 0 DATA, 1 DIR, 2 IRQMASK, 3 EDGECAP, 4 OUTSET, 5 OUTCLR; 6-7 reserved (read 0, writes ignored).
REQ-015 Writes take effect when chipselect=1 and write_n=0 at a clk edge.
REQ-016 DATA write SHALL load the output register; DATA read SHALL return the synchronised input.
REQ-017 OUTSET write SHALL OR writedata into the output register; OUTCLR write SHALL AND-NOT it; both read 0.
REQ-018 DIR bit =1 SHALL make the bit an output; pin_oe = DIR and pin_out = output register.
REQ-019 pin_in SHALL pass a 2-flop synchroniser; the edge detector compares the 2nd stage with a 3rd delay stage.
REQ-020 Input-to-DATA-read visibility SHALL be 2 clk edges after pin_in settles; edge-to-EDGECAP set SHALL be 3 edges.
REQ-021 A detected edge of the configured type SHALL set its EDGECAP bit, sticky until cleared.
REQ-022 An EDGECAP write SHALL clear each bit written 1; a same-cycle set and clear on one bit SHALL leave it set.
REQ-023 irq SHALL be registered and SHALL equal |(EDGECAP & IRQMASK) from the previous cycle.
REQ-024 Read latency: readdata SHALL be valid on the edge following a cycle with chipselect=1 and read_n=0, and SHALL hold until the next read.
REQ-025 A simultaneous read and write to one register SHALL return the pre-write value.

Reset
REQ-026 While reset_n=0: output register = RESET_VALUE; DIR, IRQMASK, EDGECAP, synchroniser stages, readdata and irq = 0.
REQ-027 Release SHALL NOT create a false edge: the delay stage SHALL reset equal to stage 2 (both 0).

Configuration
REQ-028 Macro AVL_GPIO_IRQ_EN defined: IRQMASK, EDGECAP, the edge detector and irq SHALL exist as specified.
REQ-029 Macro AVL_GPIO_IRQ_EN undefined: those SHALL be omitted; addresses 2-3 read 0, writes ignored; irq tied 0.

Structure
REQ-030 Package avl_gpio_pkg SHALL hold the register address constants and the edge-type enumeration.
REQ-031 Sub-module gpio_sync_edge (WIDTH-wide synchroniser plus edge detector) SHALL be instantiated once.

Verification
REQ-032 Reset with RESET_VALUE=8'hA5 -> pin_out=8'hA5, pin_oe=0, irq=0, readdata=0.
REQ-033 Write DATA=8'h0F; OUTSET 8'hF0; OUTCLR 8'h03 -> pin_out sequence 0F, FF, FC.
REQ-034 DIR=8'hFF, pin_in toggled 00->3C -> DATA read returns 3C, not before 2 edges after the change.
REQ-035 EDGE_TYPE=0, IRQMASK=8'h01, rising edge on pin_in[0] -> EDGECAP=01 and irq=1 one edge later; write EDGECAP=01 -> irq=0.
REQ-036 Edge on bit 0 in the same cycle as an EDGECAP clear of bit 0 -> bit remains 1.
REQ-037 Macro undefined -> edges on pin_in leave irq=0; reads of addresses 2-3 return 0.

Source files
------------

// File: rtl/avl_gpio_pkg.sv
// Shared constants for the Avalon-MM GPIO port: bus widths, register map and edge-type encoding.
package avl_gpio_pkg;

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned BUS_W  = 32;

    localparam logic [ADDR_W-1:0] ADDR_DATA    = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_DIR     = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_IRQMASK = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_EDGECAP = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_OUTSET  = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_OUTCLR  = 3'd5;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_type_e;

endpackage

// File: rtl/gpio_sync_edge.sv
// Two-flop pin synchroniser; with AVL_GPIO_IRQ_EN defined, adds a third delay stage and
// an edge detector selected by EDGE_TYPE.
module gpio_sync_edge
    import avl_gpio_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned EDGE_TYPE = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_pin,
    output logic [WIDTH-1:0] o_sync
`ifdef AVL_GPIO_IRQ_EN
    ,
    output logic [WIDTH-1:0] o_edge_c
`endif
);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= i_pin;
            r_s2 <= r_s1;
        end
    end

    assign o_sync = r_s2;

`ifdef AVL_GPIO_IRQ_EN
    logic [WIDTH-1:0] r_s3;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;

    // Delay stage resets to the same value as stage 2, so reset release never looks like an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s3 <= '0;
        end else begin
            r_s3 <= r_s2;
        end
    end

    assign w_rise = r_s2 & ~r_s3;
    assign w_fall = ~r_s2 & r_s3;

    always_comb begin
        o_edge_c = '0;
        if (EDGE_TYPE == 32'(EDGE_RISE)) begin
            o_edge_c = w_rise;
        end else if (EDGE_TYPE == 32'(EDGE_FALL)) begin
            o_edge_c = w_fall;
        end else if (EDGE_TYPE == 32'(EDGE_ANY)) begin
            o_edge_c = w_rise | w_fall;
        end
    end
`else
    logic [31:0] w_unused_edge_type;
    assign w_unused_edge_type = 32'(EDGE_TYPE);
`endif

endmodule

// File: rtl/avl_gpio_port.sv
// Avalon-MM GPIO port: output/direction registers, set/clear aliases and registered reads.
// Define AVL_GPIO_IRQ_EN to build the edge-capture interrupt block (IRQMASK, EDGECAP, irq).
module avl_gpio_port
    import avl_gpio_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned      EDGE_TYPE   = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic              read_n,
    input  logic [BUS_W-1:0]  writedata,
    output logic [BUS_W-1:0]  readdata,
    input  logic [WIDTH-1:0]  pin_in,
    output logic [WIDTH-1:0]  pin_out,
    output logic [WIDTH-1:0]  pin_oe,
    output logic              irq
);

    logic             w_wr;
    logic             w_rd;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] w_out_nxt;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] w_dir_nxt;
    logic [BUS_W-1:0] r_rdata;
    logic [BUS_W-1:0] w_rdata_nxt;
    logic             w_unused_wdata;

    assign w_wr           = chipselect & ~write_n;
    assign w_rd           = chipselect & ~read_n;
    assign w_wdata        = writedata[WIDTH-1:0];
    assign w_unused_wdata = ^writedata;

`ifdef AVL_GPIO_IRQ_EN
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] w_mask_nxt;
    logic [WIDTH-1:0] r_cap;
    logic [WIDTH-1:0] w_cap_nxt;
    logic             r_irq;
`endif

    gpio_sync_edge #(
        .WIDTH     (WIDTH),
        .EDGE_TYPE (EDGE_TYPE)
    ) u_sync_edge (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_pin    (pin_in),
        .o_sync   (w_sync)
`ifdef AVL_GPIO_IRQ_EN
        ,
        .o_edge_c (w_edge)
`endif
    );

    // Output register and direction updates from bus writes.
    always_comb begin
        w_out_nxt = r_out;
        w_dir_nxt = r_dir;
        if (w_wr) begin
            case (address)
                ADDR_DATA:   w_out_nxt = w_wdata;
                ADDR_DIR:    w_dir_nxt = w_wdata;
                ADDR_OUTSET: w_out_nxt = r_out | w_wdata;
                ADDR_OUTCLR: w_out_nxt = r_out & ~w_wdata;
                default:     ;
            endcase
        end
    end

    // Read mux samples pre-write state, so a same-cycle read and write returns the old value.
    always_comb begin
        w_rdata_nxt = r_rdata;
        if (w_rd) begin
            case (address)
                ADDR_DATA:    w_rdata_nxt = BUS_W'(w_sync);
                ADDR_DIR:     w_rdata_nxt = BUS_W'(r_dir);
`ifdef AVL_GPIO_IRQ_EN
                ADDR_IRQMASK: w_rdata_nxt = BUS_W'(r_mask);
                ADDR_EDGECAP: w_rdata_nxt = BUS_W'(r_cap);
`endif
                default:      w_rdata_nxt = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out   <= RESET_VALUE;
            r_dir   <= '0;
            r_rdata <= '0;
        end else begin
            r_out   <= w_out_nxt;
            r_dir   <= w_dir_nxt;
            r_rdata <= w_rdata_nxt;
        end
    end

    assign pin_out  = r_out;
    assign pin_oe   = r_dir;
    assign readdata = r_rdata;

`ifdef AVL_GPIO_IRQ_EN
    // Write-one-to-clear, with a new edge winning over a same-cycle clear.
    always_comb begin
        w_mask_nxt = r_mask;
        w_cap_nxt  = r_cap;
        if (w_wr && (address == ADDR_IRQMASK)) begin
            w_mask_nxt = w_wdata;
        end
        if (w_wr && (address == ADDR_EDGECAP)) begin
            w_cap_nxt = r_cap & ~w_wdata;
        end
        w_cap_nxt = w_cap_nxt | w_edge;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mask <= '0;
            r_cap  <= '0;
            r_irq  <= 1'b0;
        end else begin
            r_mask <= w_mask_nxt;
            r_cap  <= w_cap_nxt;
            r_irq  <= |(r_cap & r_mask);
        end
    end

    assign irq = r_irq;
`else
    assign irq = 1'b0;
`endif

endmodule
